// File: rtl/serial_pkg.sv
// Shared types and default constants for the serial transmitter.
package serial_pkg;

   localparam int unsigned CLKS_PER_BIT = 434;
   localparam int unsigned DATA_WIDTH   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage : serial_pkg

// File: rtl/bit_timer.sv
// Baud counter: runs 0..CLKS_PER_BIT-1 while enabled, held at 0 otherwise.
module bit_timer #(
   parameter int unsigned CLKS_PER_BIT = serial_pkg::CLKS_PER_BIT
) (
   input  logic clock,
   input  logic reset_L,
   input  logic en,
   output logic tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_count;

   // Count cycles within the current bit; restart from 0 whenever disabled.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         r_count <= '0;
      end else if (!en) begin
         r_count <= '0;
      end else if (r_count == LAST_CNT) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   // Last cycle of the current bit.
   assign tick = (r_count == LAST_CNT);

endmodule : bit_timer

// File: rtl/serial_transmitter.sv
// UART-style transmitter: start bit, LSB-first payload, STOP_BITS stop bits.
module serial_transmitter
   import serial_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = serial_pkg::CLKS_PER_BIT,
   parameter int unsigned DATA_WIDTH   = serial_pkg::DATA_WIDTH,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                  clock,
   input  logic                  reset_L,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  send,
   output logic                  ready,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
   localparam logic ONE_STOP = 1'(STOP_BITS == 1);

   tx_state_t             r_state;
   logic [DATA_WIDTH-1:0] r_shreg;
   logic [IDX_W-1:0]      r_bit_idx;
   logic                  r_last_stop;
   logic                  r_tx;
   logic                  r_ready;
   logic                  r_busy;

   logic                  w_tick;
   logic                  w_timer_en;

   assign w_timer_en = (r_state != IDLE);

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clock   (clock),
      .reset_L (reset_L),
      .en      (w_timer_en),
      .tick    (w_tick)
   );

   // Frame sequencer: owns the line, the payload shifter and the handshake flags.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         r_state     <= IDLE;
         r_shreg     <= '0;
         r_bit_idx   <= '0;
         r_last_stop <= 1'b0;
         r_tx        <= 1'b1;
         r_ready     <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (send) begin
                  r_shreg   <= data;
                  r_bit_idx <= '0;
                  r_tx      <= 1'b0;
                  r_ready   <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= START;
               end
            end
            START: begin
               if (w_tick) begin
                  r_tx    <= r_shreg[0];
                  r_shreg <= r_shreg >> 1;
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_tick) begin
                  if (r_bit_idx == LAST_IDX) begin
                     r_tx        <= 1'b1;
                     r_last_stop <= ONE_STOP;
                     r_state     <= STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + IDX_W'(1);
                     r_tx      <= r_shreg[0];
                     r_shreg   <= r_shreg >> 1;
                  end
               end
            end
            STOP: begin
               if (w_tick) begin
                  if (r_last_stop) begin
                     r_last_stop <= 1'b0;
                     r_bit_idx   <= '0;
                     r_ready     <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= IDLE;
                  end else begin
                     r_last_stop <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Outputs come straight from registers; done marks the final cycle of the last stop bit.
   assign tx    = r_tx;
   assign ready = r_ready;
   assign busy  = r_busy;
   assign done  = r_last_stop & w_tick;

endmodule : serial_transmitter

// File: tb/tb_serial_transmitter.sv
// Bench: two transmitters (one and two stop bits) share stimulus; each is
// compared every cycle against a position-in-frame reference model.
module tb_serial_transmitter;

   localparam int unsigned CPB = 4;
   localparam int unsigned DW  = 8;

   logic          clock = 1'b0;
   logic          reset_L;
   logic [DW-1:0] data;
   logic          send;

   logic ready1, tx1, busy1, done1;
   logic ready2, tx2, busy2, done2;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: cycles since acceptance (0 = idle) and latched payload.
   int            m_pos[2]   = '{0, 0};
   logic [DW-1:0] m_frame[2] = '{8'h00, 8'h00};

   always #5 clock = ~clock;

   serial_transmitter #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .STOP_BITS(1)) u_dut1 (
      .clock   (clock),
      .reset_L (reset_L),
      .data    (data),
      .send    (send),
      .ready   (ready1),
      .tx      (tx1),
      .busy    (busy1),
      .done    (done1)
   );

   serial_transmitter #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .STOP_BITS(2)) u_dut2 (
      .clock   (clock),
      .reset_L (reset_L),
      .data    (data),
      .send    (send),
      .ready   (ready2),
      .tx      (tx2),
      .busy    (busy2),
      .done    (done2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int frame_len(input int k);
      return (1 + DW + (k + 1)) * CPB;
   endfunction

   // Line level at a given cycle position (1-based) of a frame.
   function automatic logic line_bit(input logic [DW-1:0] d, input int pos);
      int b;
      b = (pos - 1) / CPB;
      if (b == 0) return 1'b0;
      if (b <= DW) return d[b-1];
      return 1'b1;
   endfunction

   // Model advance on each rising edge.
   always @(posedge clock) begin
      for (int k = 0; k < 2; k++) begin
         if (!reset_L) begin
            m_pos[k] = 0;
         end else if (m_pos[k] == 0) begin
            if (send) begin
               m_pos[k]   = 1;
               m_frame[k] = data;
            end
         end else if (m_pos[k] == frame_len(k)) begin
            m_pos[k] = 0;
         end else begin
            m_pos[k] = m_pos[k] + 1;
         end
      end
   end

   // Reset aborts any frame immediately.
   always @(negedge reset_L) begin
      m_pos[0] = 0;
      m_pos[1] = 0;
   end

   // Compare both DUTs against the model away from the active edge.
   always @(negedge clock) begin
      logic o_tx[2], o_rdy[2], o_busy[2], o_done[2];
      logic e_tx;
      o_tx   = '{tx1, tx2};
      o_rdy  = '{ready1, ready2};
      o_busy = '{busy1, busy2};
      o_done = '{done1, done2};
      for (int k = 0; k < 2; k++) begin
         e_tx = (m_pos[k] == 0) ? 1'b1 : line_bit(m_frame[k], m_pos[k]);
         chk($sformatf("tx[%0d]", k),    32'(o_tx[k]),   32'(e_tx));
         chk($sformatf("ready[%0d]", k), 32'(o_rdy[k]),  32'(m_pos[k] == 0));
         chk($sformatf("busy[%0d]", k),  32'(o_busy[k]), 32'(m_pos[k] != 0));
         chk($sformatf("done[%0d]", k),  32'(o_done[k]), 32'(m_pos[k] == frame_len(k)));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clock);
         #1;
      end
   endtask

   task automatic pulse_send(input logic [DW-1:0] d);
      data = d;
      send = 1'b1;
      step(1);
      send = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_L = 1'b0;
      send    = 1'b0;
      data    = '0;
      step(3);
      chk("reset_tx",    32'(tx1),    32'd1);
      chk("reset_ready", 32'(ready1), 32'd1);
      chk("reset_busy",  32'(busy2),  32'd0);
      chk("reset_done",  32'(done2),  32'd0);
      reset_L = 1'b1;
      step(2);

      // Single frame
      pulse_send(8'hA5);
      data = DW'($urandom);
      step(50);

      // Back-to-back with send held high
      data = 8'h00;
      send = 1'b1;
      step(2);
      data = 8'hFF;
      step(48);
      send = 1'b0;
      step(50);

      // Request during an active frame is dropped
      pulse_send(8'h81);
      step(14);
      pulse_send(8'h3C);
      step(60);

      // Payload changes after acceptance do not leak into the frame
      pulse_send(8'h5A);
      step(2);
      data = DW'($urandom);
      step(50);

      // Reset in the middle of data bit 3
      pulse_send(DW'($urandom));
      step(16);
      reset_L = 1'b0;
      #1;
      chk("abort_tx1",    32'(tx1),    32'd1);
      chk("abort_busy1",  32'(busy1),  32'd0);
      chk("abort_ready1", 32'(ready1), 32'd1);
      chk("abort_tx2",    32'(tx2),    32'd1);
      chk("abort_busy2",  32'(busy2),  32'd0);
      chk("abort_ready2", 32'(ready2), 32'd1);
      step(2);
      reset_L = 1'b1;
      pulse_send(8'h11);
      step(50);

      // Randomized traffic including requests that must be ignored
      repeat (25) begin
         pulse_send(DW'($urandom));
         step(int'($urandom_range(0, 30)));
         if ($urandom_range(0, 1) == 1) pulse_send(DW'($urandom));
         step(int'($urandom_range(0, 60)));
      end
      step(60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_serial_transmitter
